// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM geometry shared with the controller, plus the BIST state encoding and test pattern.
package sdram_pkg;
   localparam int BANK_W = 2;
   localparam int ROW_W  = 13;
   localparam int COL_W  = 10;
   localparam int ADDR_W = BANK_W + ROW_W + COL_W;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_GAP, S_RD, S_RD_GAP, S_DONE} bist_state_t;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] seed);
      return a[15:0] ^ {7'b0, a[24:16]} ^ seed;
   endfunction
endpackage

// File: rtl/sdram_bist.sv
// sdram_bist: writes an address-derived pattern over a word range through the controller
// request ports, reads it back and reports pass/fail, error count and first failing word.
module sdram_bist
   import sdram_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              istart,
   input  logic [ADDR_W-1:0] iaddr_first,
   input  logic [ADDR_W-1:0] iaddr_last,
   input  logic [DATA_W-1:0] iseed,
   output logic              owrite_req,
   output logic [ADDR_W-1:0] owrite_address,
   output logic [DATA_W-1:0] owrite_data,
   input  logic              iwrite_ack,
   output logic              oread_req,
   output logic [ADDR_W-1:0] oread_address,
   input  logic [DATA_W-1:0] iread_data,
   input  logic              iread_ack,
   output logic              obusy,
   output logic              odone,
   output logic              opass,
   output logic              otimeout,
   output logic [15:0]       oerr_count,
   output logic [ADDR_W-1:0] ofirst_err_addr,
   output logic [DATA_W-1:0] ofirst_err_data
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   bist_state_t       r_state;
   logic [ADDR_W-1:0] r_cur, r_first, r_last;
   logic [DATA_W-1:0] r_seed;
   logic [WD_W-1:0]   r_wd;
   logic              w_wd_exp, w_last, w_mis;
   logic [15:0]       w_err_inc;

   assign w_wd_exp  = r_wd == WD_W'(TIMEOUT_CYCLES - 1);
   assign w_last    = r_cur == r_last;
   assign w_mis     = iread_data != pattern(r_cur, r_seed);
   assign w_err_inc = &oerr_count ? oerr_count : oerr_count + 16'd1;

   always_ff @(posedge iclk) begin
      if (!ireset) begin
         r_state         <= S_IDLE;
         r_cur           <= '0;
         r_first         <= '0;
         r_last          <= '0;
         r_seed          <= '0;
         r_wd            <= '0;
         owrite_req      <= 1'b0;
         owrite_address  <= '0;
         owrite_data     <= '0;
         oread_req       <= 1'b0;
         oread_address   <= '0;
         obusy           <= 1'b0;
         odone           <= 1'b0;
         opass           <= 1'b0;
         otimeout        <= 1'b0;
         oerr_count      <= '0;
         ofirst_err_addr <= '0;
         ofirst_err_data <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (istart) begin
               r_first         <= iaddr_first;
               r_last          <= iaddr_last;
               r_seed          <= iseed;
               r_cur           <= iaddr_first;
               r_wd            <= '0;
               opass           <= 1'b0;
               otimeout        <= 1'b0;
               oerr_count      <= '0;
               ofirst_err_addr <= '0;
               ofirst_err_data <= '0;
               if (iaddr_first > iaddr_last) begin
                  r_state <= S_DONE;
                  odone   <= 1'b1;
               end else begin
                  r_state        <= S_WR;
                  odone          <= 1'b0;
                  obusy          <= 1'b1;
                  owrite_req     <= 1'b1;
                  owrite_address <= iaddr_first;
                  owrite_data    <= pattern(iaddr_first, iseed);
               end
            end
            S_WR: if (iwrite_ack) begin
               owrite_req <= 1'b0;
               r_cur      <= w_last ? r_first : r_cur + 1'b1;
               r_state    <= w_last ? S_RD_GAP : S_WR_GAP;
            end else if (w_wd_exp) begin
               owrite_req <= 1'b0;
               otimeout   <= 1'b1;
               odone      <= 1'b1;
               obusy      <= 1'b0;
               r_state    <= S_DONE;
            end else begin
               r_wd <= r_wd + 1'b1;
            end
            S_WR_GAP: begin
               r_state        <= S_WR;
               r_wd           <= '0;
               owrite_req     <= 1'b1;
               owrite_address <= r_cur;
               owrite_data    <= pattern(r_cur, r_seed);
            end
            S_RD: if (iread_ack) begin
               oread_req <= 1'b0;
               if (w_mis) begin
                  oerr_count <= w_err_inc;
                  if (oerr_count == 16'd0) begin
                     ofirst_err_addr <= r_cur;
                     ofirst_err_data <= iread_data;
                  end
               end
               // last compare precedes increment, so the top address never wraps
               if (w_last) begin
                  r_state <= S_DONE;
                  odone   <= 1'b1;
                  obusy   <= 1'b0;
                  opass   <= !w_mis && oerr_count == 16'd0;
               end else begin
                  r_cur   <= r_cur + 1'b1;
                  r_state <= S_RD_GAP;
               end
            end else if (w_wd_exp) begin
               oread_req <= 1'b0;
               otimeout  <= 1'b1;
               odone     <= 1'b1;
               obusy     <= 1'b0;
               r_state   <= S_DONE;
            end else begin
               r_wd <= r_wd + 1'b1;
            end
            S_RD_GAP: begin
               r_state       <= S_RD;
               r_wd          <= '0;
               oread_req     <= 1'b1;
               oread_address <= r_cur;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: scoreboard bench; a controller model with memory answers requests,
// a monitor pops expected writes/reads/results as the DUT presents them.
module tb_sdram_bist;
   typedef struct {logic [24:0] a; logic [15:0] d;} wr_t;
   typedef struct {logic pass; logic [15:0] err; logic [24:0] fa; logic [15:0] fd; logic to;} res_t;

   logic        iclk, ireset, istart;
   logic [24:0] iaddr_first, iaddr_last;
   logic [15:0] iseed;
   logic        owrite_req, oread_req, iwrite_ack, iread_ack;
   logic [24:0] owrite_address, oread_address, ofirst_err_addr;
   logic [15:0] owrite_data, iread_data, oerr_count, ofirst_err_data;
   logic        obusy, odone, opass, otimeout;

   logic        t_start, t_wr_req, t_rd_req, t_busy, t_done, t_pass, t_to, t_ack;
   logic [24:0] t_wr_addr, t_rd_addr, t_fea;
   logic [15:0] t_wr_data, t_rdata, t_err, t_fed;

   wr_t         exp_wr[$];
   logic [24:0] exp_rd[$];
   res_t        exp_res[$];
   logic [15:0] mem[logic [24:0]];
   int          n_chk = 0, n_fail = 0, lat = 5;
   bit          rand_lat = 0, flip_en = 0;
   logic [24:0] flip_addr = '0;

   sdram_bist u_dut (
      .iclk(iclk), .ireset(ireset), .istart(istart),
      .iaddr_first(iaddr_first), .iaddr_last(iaddr_last), .iseed(iseed),
      .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
      .iwrite_ack(iwrite_ack), .oread_req(oread_req), .oread_address(oread_address),
      .iread_data(iread_data), .iread_ack(iread_ack), .obusy(obusy), .odone(odone),
      .opass(opass), .otimeout(otimeout), .oerr_count(oerr_count),
      .ofirst_err_addr(ofirst_err_addr), .ofirst_err_data(ofirst_err_data)
   );

   sdram_bist #(.TIMEOUT_CYCLES(16)) u_to (
      .iclk(iclk), .ireset(ireset), .istart(t_start),
      .iaddr_first(iaddr_first), .iaddr_last(iaddr_last), .iseed(iseed),
      .owrite_req(t_wr_req), .owrite_address(t_wr_addr), .owrite_data(t_wr_data),
      .iwrite_ack(t_ack), .oread_req(t_rd_req), .oread_address(t_rd_addr),
      .iread_data(t_rdata), .iread_ack(t_ack), .obusy(t_busy), .odone(t_done),
      .opass(t_pass), .otimeout(t_to), .oerr_count(t_err),
      .ofirst_err_addr(t_fea), .ofirst_err_data(t_fed)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic extra(input string nm, input logic [127:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %0h, expected nothing", nm, act);
   endtask

   // controller model: acks after lat cycles, stores writes, returns stored data on reads
   initial begin : model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge iclk);
         #1;
         iwrite_ack = 1'b0;
         iread_ack  = 1'b0;
         iread_data = '0;
         if (owrite_req || oread_req) begin
            if (cnt >= lat) begin
               cnt = 0;
               if (owrite_req) begin
                  mem[owrite_address] = owrite_data;
                  iwrite_ack = 1'b1;
               end else begin
                  iread_data = (mem.exists(oread_address) ? mem[oread_address] : 16'h0)
                               ^ ((flip_en && oread_address == flip_addr) ? 16'h1 : 16'h0);
                  iread_ack = 1'b1;
               end
               if (rand_lat) lat = $urandom_range(20, 1);
            end else cnt++;
         end else cnt = 0;
      end
   end

   initial begin : monitor
      logic pw, pr, pd, pwa, pra;
      logic [24:0] ha, hra;
      logic [15:0] hd;
      wr_t w;
      res_t r;
      logic [24:0] ra;
      pw = 0; pr = 0; pd = 0; pwa = 0; pra = 0; ha = '0; hra = '0; hd = '0;
      forever begin
         @(negedge iclk);
         if (ireset) begin
            if (owrite_req || oread_req) chk("req_excl", owrite_req & oread_req, 0);
            if (pwa) chk("wr_drop_after_ack", owrite_req, 0);
            if (pra) chk("rd_drop_after_ack", oread_req, 0);
            if (owrite_req && pw) chk("wr_stable", {owrite_address, owrite_data}, {ha, hd});
            if (oread_req && pr) chk("rd_stable", oread_address, hra);
            if (owrite_req && !pw) begin
               if (exp_wr.size() == 0) extra("wr_extra", owrite_address);
               else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", owrite_address, w.a);
                  chk("wr_data", owrite_data, w.d);
               end
            end
            if (oread_req && !pr) begin
               if (exp_rd.size() == 0) extra("rd_extra", oread_address);
               else begin
                  ra = exp_rd.pop_front();
                  chk("rd_addr", oread_address, ra);
               end
            end
            if (odone && !pd) begin
               if (exp_res.size() == 0) extra("done_extra", odone);
               else begin
                  r = exp_res.pop_front();
                  chk("res_pass", opass, r.pass);
                  chk("res_err_count", oerr_count, r.err);
                  chk("res_first_addr", ofirst_err_addr, r.fa);
                  chk("res_first_data", ofirst_err_data, r.fd);
                  chk("res_timeout", otimeout, r.to);
                  chk("res_busy", obusy, 0);
               end
            end
         end
         pw = owrite_req; pr = oread_req; pd = odone;
         pwa = iwrite_ack; pra = iread_ack;
         ha = owrite_address; hd = owrite_data; hra = oread_address;
      end
   end

   task automatic pulse_start();
      istart = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!odone && n < 20000) begin
         @(negedge iclk);
         n++;
      end
      chk("done_reached", odone, 1);
      @(negedge iclk);
   endtask

   task automatic run(input logic [24:0] f, input logic [24:0] l, input logic [15:0] s);
      iaddr_first = f; iaddr_last = l; iseed = s;
      pulse_start();
      wait_done();
      chk("writes_left", exp_wr.size(), 0);
      chk("reads_left", exp_rd.size(), 0);
      chk("results_left", exp_res.size(), 0);
   endtask

   task automatic push_range(input int n, input logic [15:0] s);
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back('{a: 25'(i), d: s ^ 16'(i)});
         exp_rd.push_back(25'(i));
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_flags"}, {owrite_req, oread_req, obusy, odone, opass, otimeout}, 0);
      chk({nm, "_addr"}, {owrite_address, oread_address, ofirst_err_addr}, 0);
      chk({nm, "_data"}, {owrite_data, oerr_count, ofirst_err_data}, 0);
   endtask

   initial begin : stim
      int n;
      ireset = 1'b0; istart = 1'b0; t_start = 1'b0; t_ack = 1'b0; t_rdata = '0;
      iaddr_first = '0; iaddr_last = '0; iseed = '0;
      iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;
      repeat (3) @(negedge iclk);
      chk_zero("reset");
      chk("reset_to_inst", {t_wr_req, t_busy, t_done, t_to}, 0);
      ireset = 1'b1;
      @(negedge iclk);

      // 0..3, seed 0, fixed latency
      exp_wr.push_back('{a: 25'd0, d: 16'h0000});
      exp_wr.push_back('{a: 25'd1, d: 16'h0001});
      exp_wr.push_back('{a: 25'd2, d: 16'h0002});
      exp_wr.push_back('{a: 25'd3, d: 16'h0003});
      for (int i = 0; i < 4; i++) exp_rd.push_back(25'(i));
      exp_res.push_back('{pass: 1, err: 0, fa: 0, fd: 0, to: 0});
      run(25'd0, 25'd3, 16'h0000);

      // same run, bit0 flipped on the read of addr 2
      flip_en = 1; flip_addr = 25'd2;
      push_range(4, 16'h0000);
      exp_res.push_back('{pass: 0, err: 1, fa: 25'd2, fd: 16'h0003, to: 0});
      run(25'd0, 25'd3, 16'h0000);
      flip_en = 0;

      // random ack latency over 0..15
      rand_lat = 1;
      push_range(16, 16'h1234);
      exp_res.push_back('{pass: 1, err: 0, fa: 0, fd: 0, to: 0});
      run(25'd0, 25'd15, 16'h1234);
      rand_lat = 0; lat = 3;

      // top of the address space: single word, no wrap
      exp_wr.push_back('{a: 25'h1FFFFFF, d: 16'h5BA5});
      exp_rd.push_back(25'h1FFFFFF);
      exp_res.push_back('{pass: 1, err: 0, fa: 0, fd: 0, to: 0});
      run(25'h1FFFFFF, 25'h1FFFFFF, 16'hA5A5);

      // watchdog on the 16-cycle instance: no ack ever arrives
      iaddr_first = 25'd0; iaddr_last = 25'd3;
      t_start = 1'b1;
      @(negedge iclk);
      t_start = 1'b0;
      n = 0;
      while (t_wr_req && n < 100) begin
         n++;
         @(negedge iclk);
      end
      chk("to_req_cycles", n, 16);
      chk("to_flags", {t_done, t_to, t_pass, t_busy, t_rd_req}, 5'b11000);

      // reset during the read phase, then a clean run
      push_range(16, 16'h0000);
      iaddr_first = 25'd0; iaddr_last = 25'd15; iseed = 16'h0000;
      pulse_start();
      n = 0;
      while (!oread_req && n < 5000) begin
         n++;
         @(negedge iclk);
      end
      chk("reached_read_phase", oread_req, 1);
      repeat (2) @(negedge iclk);
      ireset = 1'b0;
      @(negedge iclk);
      chk_zero("midreset");
      exp_wr.delete(); exp_rd.delete(); exp_res.delete();
      ireset = 1'b1;
      @(negedge iclk);
      push_range(4, 16'h00FF);
      exp_res.push_back('{pass: 1, err: 0, fa: 0, fd: 0, to: 0});
      run(25'd0, 25'd3, 16'h00FF);

      // empty range: done on the next cycle, fail, no requests
      iaddr_first = 25'd5; iaddr_last = 25'd4;
      pulse_start();
      chk("empty_flags", {odone, opass, obusy, otimeout, owrite_req, oread_req}, 6'b100000);
      repeat (5) @(negedge iclk);
      chk("empty_idle", {owrite_req, oread_req, obusy, odone}, 4'b0001);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
